// File: rtl/bru_pkg.sv
// bru_pkg: shared types and constants for the branch resolve unit
package bru_pkg;
    typedef enum logic {RUN, SQUASH} state_t;
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
    localparam int PC_W = 64;
    localparam int INST_BYTES = 4;
endpackage

// File: rtl/bru_stats.sv
// bru_stats: saturating counters of predictor updates and flush cycles
module bru_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    input  logic        flush,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (flush && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch check, flush/redirect and predictor update
// Define BRANCH_STATS_EN to add the stat_branches/stat_mispredicts counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int N_REG  = 4,
    parameter int N_BITS = $clog2(N_REG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              pred_taken,
    input  logic [PC_W-1:0]   pred_target,
    input  logic              stall,
    input  logic              id_is_branch,
    input  logic              id_taken,
    input  logic [PC_W-1:0]   id_target,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              upd_valid,
    output logic [N_BITS-1:0] upd_index,
    output logic              upd_correct,
    output logic [PC_W-1:0]   upd_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);
    state_t            state, state_d;
    logic              slot_v, slot_ptaken;
    logic [PC_W-1:0]   slot_pc, slot_ptarget, seq_pc, correct_pc;
    logic              eval, br_eval, br_miss, mispredict;

    always_comb begin
        eval       = slot_v && !stall && state == RUN;
        br_eval    = eval && id_is_branch;
        seq_pc     = slot_pc + PC_W'(INST_BYTES);
        br_miss    = (slot_ptaken != id_taken) || (slot_ptaken && id_taken && slot_ptarget != id_target);
        mispredict = eval && (id_is_branch ? br_miss : slot_ptaken);
        correct_pc = (id_is_branch && id_taken) ? id_target : seq_pc;
        state_d    = mispredict ? SQUASH : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            slot_v      <= 1'b0;
            flush       <= 1'b0;
            upd_valid   <= 1'b0;
            upd_correct <= 1'b0;
            upd_index   <= '0;
            upd_target  <= '0;
            redirect_pc <= '0;
        end else begin
            state     <= state_d;
            flush     <= mispredict;
            upd_valid <= br_eval;
            if (mispredict) redirect_pc <= correct_pc;
            if (br_eval) begin
                upd_index   <= slot_pc[2*N_BITS-1:N_BITS];
                upd_correct <= !br_miss;
                upd_target  <= id_target;
            end
            // the squash cycle kills the wrong-path slot even while stalled
            if (state == SQUASH) slot_v <= 1'b0;
            else if (!stall) slot_v <= if_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RUN && !stall) begin
            slot_pc      <= if_pc;
            slot_ptaken  <= pred_taken;
            slot_ptarget <= pred_target;
        end
    end

`ifdef BRANCH_STATS_EN
    bru_stats u_stats (
        .clk              (clk),
        .rst              (rst),
        .upd_valid        (upd_valid),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );
`endif
endmodule
